// File: rtl/ahb_apb_bridge_pkg.sv
// Shared AHB/APB encodings and bridge FSM state codes for the Zscale peripheral bus.
package ahb_apb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [5:0] ST_IDLE   = 6'b000001;
  localparam logic [5:0] ST_SETUP  = 6'b000010;
  localparam logic [5:0] ST_ACCESS = 6'b000100;
  localparam logic [5:0] ST_DONE   = 6'b001000;
  localparam logic [5:0] ST_ERR1   = 6'b010000;
  localparam logic [5:0] ST_ERR2   = 6'b100000;

  // A single slave still needs one index bit so the decode slices stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_decode.sv
// Combinational APB window decode: haddr -> hit, slave index and one-hot select.
// Zero latency; no handshake.
module apb_addr_decode
  import ahb_apb_bridge_pkg::*;
#(
  parameter int          N_SLV     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          SLV_SHIFT = 12
) (
  input  logic [31:0]                  haddr,
  output logic                         hit,
  output logic [idx_width(N_SLV)-1:0]  idx,
  output logic [N_SLV-1:0]             psel_onehot
);

  localparam int IW  = idx_width(N_SLV);
  localparam int TOP = SLV_SHIFT + IW;
  localparam logic [IW:0] N_LIM = (IW+1)'(N_SLV);

  logic unused_low;

  assign idx = haddr[TOP-1:SLV_SHIFT];
  assign hit = (haddr[31:TOP] == BASE_ADDR[31:TOP]) && ({1'b0, idx} < N_LIM);
  assign unused_low = ^haddr[SLV_SHIFT-1:0];

  always_comb begin
    psel_onehot = '0;
    for (int i = 0; i < N_SLV; i++) begin
      psel_onehot[i] = hit && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge, one transfer in flight; zero-wait APB read completes in 3 cycles.
// Stalls AHB with hreadyout=0 through SETUP/ACCESS/ERR1; PSLVERR, misses and timeouts give a two-cycle ERROR.
module ahb_apb_bridge
  import ahb_apb_bridge_pkg::*;
#(
  parameter int          N_SLV     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          SLV_SHIFT = 12,
  parameter int          TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  input  logic [31:0]           hwdata,
  input  logic                  hreadyin,
  output logic [31:0]           hrdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           paddr,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  output logic [N_SLV-1:0]      psel,
  output logic                  penable,
  input  logic [32*N_SLV-1:0]   prdata,
  input  logic [N_SLV-1:0]      pready,
  input  logic [N_SLV-1:0]      pslverr
);

  localparam int IW = idx_width(N_SLV);
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic             dec_hit;
  logic [IW-1:0]    dec_idx;
  logic [N_SLV-1:0] dec_sel;

  logic [5:0]       state_q, state_d;
  logic [31:0]      paddr_q, paddr_d;
  logic             pwrite_q, pwrite_d;
  logic [N_SLV-1:0] sel_q, sel_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             can_accept, accept, in_xfer;
  logic             slv_rdy, slv_err;
  logic [31:0]      slv_rdata;
  logic             unused_hsize;

  apb_addr_decode #(
    .N_SLV     (N_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SHIFT (SLV_SHIFT)
  ) u_decode (
    .haddr       (haddr),
    .hit         (dec_hit),
    .idx         (dec_idx),
    .psel_onehot (dec_sel)
  );

  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept     = can_accept && hsel && hreadyin &&
                      (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);
  assign in_xfer    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  // Only the captured slave's handshake is observed; others may float anything.
  assign slv_rdy = |(pready & sel_q);
  assign slv_err = |(pslverr & sel_q);

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (idx_q == IW'(i)) slv_rdata = prdata[32*i +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    if (accept) begin
      paddr_d  = haddr;
      pwrite_d = hwrite;
      sel_d    = dec_sel;
      idx_d    = dec_idx;
    end
    // In ACCESS, cnt_q equals the number of ACCESS cycles including the current one.
    if (in_xfer && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) state_d = dec_hit ? ST_SETUP : ST_ERR1;
        else        state_d = ST_IDLE;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (slv_rdy) begin
          if (slv_err) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DONE;
            if (!pwrite_q) hrdata_d = slv_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_SETUP) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
      idx_q    <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hreadyout = !(in_xfer || (state_q == ST_ERR1));
  assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = hrdata_q;
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = hwdata;
  assign psel      = in_xfer ? sel_q : '0;
  assign penable   = (state_q == ST_ACCESS);

  assign unused_hsize = ^hsize;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: table-driven AHB transfers against a configurable APB slave model, plus hand sequences.
module tb_ahb_apb_bridge;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  logic         clk = 1'b0;
  logic         reset;
  logic         hsel;
  logic [31:0]  haddr;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [1:0]   htrans;
  logic [31:0]  hwdata;
  logic         hreadyin;
  logic [31:0]  hrdata;
  logic         hreadyout;
  logic         hresp;
  logic [31:0]  paddr;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   psel;
  logic         penable;
  logic [127:0] prdata;
  logic [3:0]   pready;
  logic [3:0]   pslverr;

  ahb_apb_bridge #(
    .N_SLV     (4),
    .BASE_ADDR (32'h8000_0000),
    .SLV_SHIFT (12),
    .TIMEOUT   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hsel      (hsel),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .htrans    (htrans),
    .hwdata    (hwdata),
    .hreadyin  (hreadyin),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .psel      (psel),
    .penable   (penable),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 clk = ~clk;
  assign hreadyin = hreadyout;

  // APB slave model: selected slave waits cfg_w ACCESS cycles; unselected ones drive ready+error.
  logic [31:0] cfg_base  = 32'h0;
  int          cfg_w     = 0;
  logic        cfg_err   = 1'b0;
  logic        cfg_never = 1'b0;
  int          acc_cnt   = 0;

  always @(posedge clk) begin
    if (penable && (psel != 4'b0)) acc_cnt <= acc_cnt + 1;
    else                           acc_cnt <= 0;
  end

  always_comb begin
    prdata  = '0;
    pready  = '0;
    pslverr = '0;
    for (int i = 0; i < 4; i++) begin
      prdata[32*i +: 32] = cfg_base + 32'(i);
      pready[i]  = psel[i] ? (penable && !cfg_never && (acc_cnt >= cfg_w)) : 1'b1;
      pslverr[i] = psel[i] ? cfg_err : 1'b1;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          w;
    logic        err;
    logic        never;
    logic [31:0] base;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    int          exp_waits;
    logic [3:0]  exp_psel;
    int          exp_pen;
  } vec_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  psel;
    int          pen;
  } exp_t;

  vec_t vecs [13];
  exp_t sb [$];
  logic [3:0] b2b_exp [6];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t       e;
    int         waits;
    int         pen;
    logic [3:0] seen;
    logic       apb_ok;
    logic       done;
    @(posedge clk); #1;
    cfg_base = v.base; cfg_w = v.w; cfg_err = v.err; cfg_never = v.never;
    hsel = 1'b1; htrans = HT_NONSEQ; haddr = v.addr; hwrite = v.wr; hsize = 3'b010;
    sb.push_back('{v.exp_resp, v.exp_rdata, v.exp_waits, v.exp_psel, v.exp_pen});
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HT_IDLE; hwdata = v.wdata;
    waits = 0; pen = 0; seen = '0; apb_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      seen |= psel;
      if (penable) pen++;
      if ((psel != 4'b0) && ((psel !== v.exp_psel) || (paddr !== v.addr) ||
          (pwrite !== v.wr) || (v.wr && (pwdata !== v.wdata)))) apb_ok = 1'b0;
      if (hreadyout) done = 1'b1;
      else           waits++;
    end
    e = sb.pop_front();
    chk($sformatf("completion@%h", v.addr), 32'(done), 32'd1);
    chk($sformatf("hresp@%h", v.addr), 32'(hresp), 32'(e.resp));
    chk($sformatf("hrdata@%h", v.addr), hrdata, e.rdata);
    chk($sformatf("wait_states@%h", v.addr), 32'(waits), 32'(e.waits));
    chk($sformatf("psel_seen@%h", v.addr), 32'(seen), 32'(e.psel));
    chk($sformatf("penable_cycles@%h", v.addr), 32'(pen), 32'(e.pen));
    chk($sformatf("apb_stable@%h", v.addr), 32'(apb_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          addr          wr    wdata         w  err   never base          resp  rdata         wt psel     pen
    vecs[0]  = '{32'h8000_0000, 1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 2, 4'b0001, 1};
    vecs[1]  = '{32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00A5, 5, 4'b0010, 4};
    vecs[2]  = '{32'h9000_0000, 1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_00A5, 1, 4'b0000, 0};
    vecs[3]  = '{32'h8000_2000, 1'b0, 32'h0,        0, 1'b1, 1'b0, 32'h7777_0000, 1'b1, 32'h0000_00A5, 3, 4'b0100, 1};
    vecs[4]  = '{32'h8000_3000, 1'b0, 32'h0,        0, 1'b0, 1'b1, 32'h6666_0000, 1'b1, 32'h0000_00A5, 6, 4'b1000, 4};
    vecs[5]  = '{32'h8000_2010, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'h1234_0000, 1'b0, 32'h1234_0002, 3, 4'b0100, 2};
    vecs[6]  = '{32'h8000_4000, 1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1234_0002, 1, 4'b0000, 0};
    vecs[7]  = '{32'h8000_3FFC, 1'b0, 32'h0,        2, 1'b0, 1'b0, 32'hCAFE_0000, 1'b0, 32'hCAFE_0003, 4, 4'b1000, 3};
    vecs[8]  = '{32'h8000_0008, 1'b1, 32'h1111_2222, 0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hCAFE_0003, 3, 4'b0001, 1};
    vecs[9]  = '{32'h7FFF_F000, 1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hCAFE_0003, 1, 4'b0000, 0};
    vecs[10] = '{32'h8000_3000, 1'b0, 32'h0,        3, 1'b0, 1'b0, 32'h55AA_0000, 1'b0, 32'h55AA_0003, 5, 4'b1000, 4};
    vecs[11] = '{32'h8000_1000, 1'b0, 32'h0,        0, 1'b0, 1'b0, 32'h0BAD_0000, 1'b0, 32'h0BAD_0001, 2, 4'b0010, 1};
    vecs[12] = '{32'h8000_1000, 1'b1, 32'h0,        0, 1'b0, 1'b0, 32'hFFFF_0000, 1'b0, 32'h0BAD_0001, 2, 4'b0010, 1};
    b2b_exp = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000};

    reset = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hsize = 3'b010;
    htrans = HT_IDLE; hwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    reset = 1'b0;

    // IDLE and BUSY with hsel high must not start an APB transfer.
    @(posedge clk); #1;
    hsel = 1'b1; htrans = HT_IDLE; haddr = 32'h8000_0000;
    @(posedge clk); #1;
    htrans = HT_BUSY;
    @(negedge clk);
    chk("idle_trans_rdy", 32'(hreadyout), 32'd1);
    chk("idle_trans_psel", 32'(psel), 32'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HT_IDLE;
    @(negedge clk);
    chk("busy_trans_rdy", 32'(hreadyout), 32'd1);
    chk("busy_trans_resp", 32'(hresp), 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Back-to-back reads: second address phase lands in DONE of the first.
    @(posedge clk); #1;
    cfg_base = 32'h1000_0000; cfg_w = 0; cfg_err = 1'b0; cfg_never = 1'b0;
    hsel = 1'b1; htrans = HT_NONSEQ; haddr = 32'h8000_0000; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HT_IDLE;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_psel%0d", k), 32'(psel), 32'(b2b_exp[k]));
      if (k == 2) begin
        chk("b2b_rd0", hrdata, 32'h1000_0000);
        hsel = 1'b1; htrans = HT_NONSEQ; haddr = 32'h8000_1000;
      end
      if (k == 3) begin
        hsel = 1'b0; htrans = HT_IDLE;
      end
      if (k == 5) chk("b2b_rd1", hrdata, 32'h1000_0001);
    end

    // Reset asserted mid-ACCESS drops the APB strobes at once.
    @(posedge clk); #1;
    cfg_never = 1'b1;
    hsel = 1'b1; htrans = HT_NONSEQ; haddr = 32'h8000_3000; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HT_IDLE;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_penable_before", 32'(penable), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_psel", 32'(psel), 32'd0);
    chk("rst_mid_penable", 32'(penable), 32'd0);
    chk("rst_mid_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_mid_hresp", 32'(hresp), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; cfg_never = 1'b0;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
